// File: rtl/fp_wb_sequencer.sv
// Write-back sequencer for the FP register file: merges pipelined FP unit results into an
// ordered FIFO, drives the single regfile write port and tracks per-register in-flight writes.
module fp_wb_sequencer #(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  localparam int REG_W     = $clog2(NUM_REGS)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_stall,
  input  logic                                i_issue_valid,
  input  logic [REG_W-1:0]                    i_issue_dest_reg,
  output logic                                o_issue_block,
  input  logic [NUM_SRC-1:0]                  i_cmpl_valid,
  input  logic [NUM_SRC-1:0][REG_W-1:0]       i_cmpl_dest_reg,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  i_cmpl_data,
  output logic                                o_full,
  output logic                                o_overflow,
  output logic                                o_fp_regfile_write_enable,
  output logic [REG_W-1:0]                    o_fp_dest_reg,
  output logic [DATA_WIDTH-1:0]               o_fp_regfile_write_data,
  output logic [NUM_REGS-1:0]                 o_pending
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(DEPTH + 1);
  localparam int SrcW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [REG_W-1:0]      r_fifo_dest [DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CntW-1:0]       r_occ;
  logic                  r_slot_valid;
  logic [REG_W-1:0]      r_slot_dest;
  logic [DATA_WIDTH-1:0] r_slot_data;
  logic                  r_overflow;
  logic [1:0]            r_cnt [NUM_REGS];

  logic                  w_consume;
  logic                  w_slot_free;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_drop;
  logic                  w_found;
  logic [SrcW-1:0]       w_first_idx;
  logic [CntW-1:0]       w_n_valid;
  logic [CntW-1:0]       w_need;
  logic [CntW-1:0]       w_free;
  logic [CntW-1:0]       w_push_cnt;
  logic [NUM_SRC-1:0]    w_enq_en;
  logic [PtrW-1:0]       w_enq_ptr [NUM_SRC];
  logic [NUM_REGS-1:0]   w_inc;
  logic [NUM_REGS-1:0]   w_dec;

  assign w_consume   = r_slot_valid & ~i_stall;
  assign w_slot_free = ~r_slot_valid | w_consume;
  assign w_pop       = w_slot_free & (r_occ != '0);
  assign w_bypass    = w_slot_free & (r_occ == '0) & (|i_cmpl_valid);
  assign w_need      = w_n_valid - CntW'(w_bypass);
  assign w_free      = CntW'(DEPTH) - r_occ + CntW'(w_pop);
  assign w_drop      = w_need > w_free;

  always_comb begin
    w_n_valid   = '0;
    w_first_idx = '0;
    w_found     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_cmpl_valid[i]) begin
        w_n_valid = w_n_valid + CntW'(1);
        if (!w_found) begin
          w_first_idx = SrcW'(i);
          w_found     = 1'b1;
        end
      end
    end
  end

  // The lowest-index valid source may go straight into the empty slot; the rest pack into the FIFO.
  always_comb begin
    w_push_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_enq_en[i]  = 1'b0;
      w_enq_ptr[i] = '0;
      if (i_cmpl_valid[i] && !w_drop && !(w_bypass && (w_first_idx == SrcW'(i)))) begin
        w_enq_en[i]  = 1'b1;
        w_enq_ptr[i] = r_wr_ptr + PtrW'(w_push_cnt);
        w_push_cnt   = w_push_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_enq_en[i]) begin
        r_fifo_dest[w_enq_ptr[i]] <= i_cmpl_dest_reg[i];
        r_fifo_data[w_enq_ptr[i]] <= i_cmpl_data[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_slot_valid <= 1'b0;
      r_slot_dest  <= '0;
      r_slot_data  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PtrW'(w_push_cnt);
      r_occ    <= r_occ - CntW'(w_pop) + w_push_cnt;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_slot_free) begin
        if (w_pop) begin
          r_slot_valid <= 1'b1;
          r_slot_dest  <= r_fifo_dest[r_rd_ptr];
          r_slot_data  <= r_fifo_data[r_rd_ptr];
        end else if (w_bypass && !w_drop) begin
          r_slot_valid <= 1'b1;
          r_slot_dest  <= i_cmpl_dest_reg[w_first_idx];
          r_slot_data  <= i_cmpl_data[w_first_idx];
        end else begin
          r_slot_valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc[r]     = i_issue_valid & ~o_issue_block & (i_issue_dest_reg == REG_W'(r));
      w_dec[r]     = w_consume & (r_slot_dest == REG_W'(r));
      o_pending[r] = (r_cnt[r] != 2'd0);
    end
  end

  // Simultaneous issue and retire of one register cancel out; retiring at zero is ignored.
  always_ff @(posedge i_clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (i_rst) begin
        r_cnt[r] <= 2'd0;
      end else if (w_inc[r] && !w_dec[r]) begin
        r_cnt[r] <= r_cnt[r] + 2'd1;
      end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != 2'd0)) begin
        r_cnt[r] <= r_cnt[r] - 2'd1;
      end
    end
  end

  assign o_issue_block             = (r_cnt[i_issue_dest_reg] == 2'd3);
  assign o_full                    = (CntW'(DEPTH) - r_occ) < CntW'(NUM_SRC);
  assign o_overflow                = r_overflow;
  assign o_fp_regfile_write_enable = r_slot_valid;
  assign o_fp_dest_reg             = r_slot_dest;
  assign o_fp_regfile_write_data   = r_slot_data;

endmodule

// File: tb/tb_fp_wb_sequencer.sv
// Bench for fp_wb_sequencer: directed scenarios plus random traffic, all checked against a
// queue-based reference model of the pending writes and per-register in-flight counts.
module tb_fp_wb_sequencer;

  localparam int Depth  = 4;
  localparam int NumSrc = 2;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             issueValid;
  logic [4:0]       issueDest;
  logic             issueBlock;
  logic [1:0]       cmplValid;
  logic [1:0][4:0]  cmplDest;
  logic [1:0][31:0] cmplData;
  logic             full;
  logic             overflow;
  logic             writeEn;
  logic [4:0]       writeDest;
  logic [31:0]      writeData;
  logic [31:0]      pending;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } entry_t;

  // Model: every accepted result waiting to be written, head is the one presented to the regfile.
  entry_t modelQ[$];
  int     modelCnt[32];
  bit     modelOvf;

  fp_wb_sequencer #(
    .NUM_SRC(NumSrc), .DEPTH(Depth), .DATA_WIDTH(32), .NUM_REGS(32)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall),
    .i_issue_valid(issueValid), .i_issue_dest_reg(issueDest), .o_issue_block(issueBlock),
    .i_cmpl_valid(cmplValid), .i_cmpl_dest_reg(cmplDest), .i_cmpl_data(cmplData),
    .o_full(full), .o_overflow(overflow),
    .o_fp_regfile_write_enable(writeEn), .o_fp_dest_reg(writeDest),
    .o_fp_regfile_write_data(writeData), .o_pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] expPend;
    expPend = '0;
    for (int r = 0; r < 32; r++) expPend[r] = (modelCnt[r] != 0);
    check("write_en", writeEn, modelQ.size() > 0);
    if (modelQ.size() > 0) begin
      check("write_dest", writeDest, modelQ[0].dest);
      check("write_data", writeData, modelQ[0].data);
    end
    check("pending", pending, expPend);
    check("overflow", overflow, modelOvf);
  endtask

  task automatic modelReset();
    modelQ.delete();
    for (int r = 0; r < 32; r++) modelCnt[r] = 0;
    modelOvf = 1'b0;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model, check after edge.
  task automatic applyStimulus(input bit r, input bit st, input bit iv, input logic [4:0] id,
                               input logic [1:0] cv, input logic [4:0] d0, input logic [31:0] x0,
                               input logic [4:0] d1, input logic [31:0] x1);
    int occ;
    int incReg;
    int decReg;
    int nValid;
    @(negedge clk);
    rst = r; stall = st; issueValid = iv; issueDest = id;
    cmplValid = cv; cmplDest[0] = d0; cmplData[0] = x0; cmplDest[1] = d1; cmplData[1] = x1;
    #1;
    occ = (modelQ.size() > 0) ? modelQ.size() - 1 : 0;
    check("full", full, (Depth - occ) < NumSrc);
    check("issue_block", issueBlock, modelCnt[id] == 3);
    if (r) begin
      modelReset();
    end else begin
      incReg = -1;
      decReg = -1;
      if (iv && modelCnt[id] != 3) incReg = int'(id);
      if (modelQ.size() > 0 && !st) begin
        decReg = int'(modelQ[0].dest);
        void'(modelQ.pop_front());
      end
      if (incReg != decReg) begin
        if (incReg >= 0) modelCnt[incReg]++;
        if (decReg >= 0 && modelCnt[decReg] > 0) modelCnt[decReg]--;
      end
      nValid = int'(cv[0]) + int'(cv[1]);
      if (modelQ.size() + nValid > Depth + 1) begin
        modelOvf = 1'b1;
      end else begin
        if (cv[0]) modelQ.push_back('{d0, x0});
        if (cv[1]) modelQ.push_back('{d1, x1});
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input bit st);
    applyStimulus(1'b0, st, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
  endtask

  task automatic issue(input logic [4:0] id);
    applyStimulus(1'b0, 1'b0, 1'b1, id, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; issueValid = 1'b0; issueDest = '0;
    cmplValid = '0; cmplDest = '0; cmplData = '0;
    modelReset();

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    check("reset_dest", writeDest, 5'd0);
    check("reset_data", writeData, 32'd0);

    $display("[TB] single write");
    issue(5'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 2'b01, 5'd5, 32'h3F80_0000, 5'd0, 32'd0);
    check("single_latency", writeEn, 1'b1);
    idle(1'b0);
    check("single_retired", pending[5], 1'b0);
    idle(1'b0);

    $display("[TB] simultaneous completions");
    issue(5'd1);
    issue(5'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 2'b11, 5'd1, 32'hAAAA_0001, 5'd2, 32'hBBBB_0002);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] stall");
    issue(5'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 2'b01, 5'd7, 32'h7777_7777, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] fill and overflow");
    for (int i = 10; i < 16; i++) issue(5'(i));
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 2'b11, 5'(10 + 2 * i), 32'h100 + 32'(i),
                    5'(11 + 2 * i), 32'h200 + 32'(i));
    check("fill_overflow", overflow, 1'b1);
    idle(1'b1);
    check("fill_full", full, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b0);
    check("overflow_sticky", overflow, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

    $display("[TB] WAW saturation");
    for (int i = 0; i < 4; i++) issue(5'd3);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 2'b01, 5'd3, 32'h3000 + 32'(i), 5'd0, 32'd0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    check("waw_retired", pending[3], 1'b0);

    $display("[TB] reset mid-queue");
    issue(5'd8);
    issue(5'd9);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 2'b11, 5'd8, 32'h8888, 5'd9, 32'h9999);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 2'b01, 5'd8, 32'h8889, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus((i % 150) == 149, ($urandom_range(0, 2) == 0), 1'($urandom),
                    5'($urandom_range(0, 7)), 2'($urandom),
                    5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
